matrix_ls_seq: RTL and testbench

MATRIX_LS_SEQ -- requirements
Module: matrix_ls_seq

---
 rtl/types_pkg.sv | 30 +++
 rtl/matrix_ls_addr_gen.sv | 13 +
 rtl/matrix_ls_seq.sv | 152 +++++++++++++++
 tb/tb_matrix_ls_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the matrix load/store sequencer: operand/op types,
// matrix geometry and the sequencer state encoding.
package types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    M_NONE  = 2'd0,
    M_LOAD  = 2'd1,
    M_STORE = 2'd2
  } matrix_mem_t;

  localparam int MAT_ROWS  = 4;
  localparam int MAT_ROW_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } matrix_ls_state_t;

  // A zero stride means densely packed rows (one 8-byte row apart).
  function automatic word_t row_pitch(input logic [3:0] stride);
    logic [3:0] s;
    s = (stride == 4'd0) ? 4'd1 : stride;
    return word_t'({s, 3'b000});
  endfunction

endpackage

// File: rtl/matrix_ls_addr_gen.sv
// Combinational row address generator: base + row * pitch, wrapping at 32 bits.
module matrix_ls_addr_gen
  import types_pkg::*;
(
  input  word_t       base_i,
  input  logic [3:0]  stride_i,
  input  logic [1:0]  row_i,
  output word_t       addr_o
);

  assign addr_o = base_i + word_t'(row_i) * row_pitch(stride_i);

endmodule

// File: rtl/matrix_ls_seq.sv
// Matrix load/store sequencer: moves 4 rows between memory and the matrix
// register file. Optional perf counters via `define MATRIX_LS_PERF_CNT_EN.
module matrix_ls_seq
  import types_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  matrix_mem_t          m_mem_type,
  input  logic [3:0]           matrix_rd,
  input  logic [3:0]           matrix_rs1,
  input  logic [3:0]           stride,
  input  word_t                base_addr,
  output logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 mem_wen,
  output word_t                mem_addr,
  output logic [MAT_ROW_W-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [MAT_ROW_W-1:0] mem_rdata,
  output logic                 mrf_wen,
  output logic [3:0]           mrf_wsel,
  output logic [1:0]           mrf_wrow,
  output logic [MAT_ROW_W-1:0] mrf_wdata,
  output logic [3:0]           mrf_rsel,
  output logic [1:0]           mrf_rrow,
  input  logic [MAT_ROW_W-1:0] mrf_rdata,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          perf_loads,
  output logic [15:0]          perf_stores
);

  matrix_ls_state_t state_q, state_d;
  logic [1:0]       row_q, row_d;
  matrix_mem_t      type_q;
  logic [3:0]       rd_q, rs1_q, stride_q;
  word_t            base_q;
  logic             accept, last_row;
  word_t            row_addr;

  assign accept   = disp_valid && (state_q == IDLE) && (m_mem_type != M_NONE);
  assign last_row = (row_q == 2'(MAT_ROWS - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      type_q   <= M_NONE;
      rd_q     <= 4'd0;
      rs1_q    <= 4'd0;
      stride_q <= 4'd0;
      base_q   <= '0;
    end else if (accept) begin
      type_q   <= m_mem_type;
      rd_q     <= matrix_rd;
      rs1_q    <= matrix_rs1;
      stride_q <= stride;
      base_q   <= base_addr;
    end
  end

  // A load response is only consumed in WAIT, so a response racing a new
  // request in REQ is never mistaken for that request's data.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          row_d   = 2'd0;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (type_q == M_STORE) begin
            if (last_row) state_d = DONE;
            else          row_d   = row_q + 2'd1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (last_row) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            row_d   = row_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  matrix_ls_addr_gen u_addr_gen (
    .base_i   (base_q),
    .stride_i (stride_q),
    .row_i    (row_q),
    .addr_o   (row_addr)
  );

  assign disp_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_req    = (state_q == REQ);
  assign mem_wen    = mem_req && (type_q == M_STORE);
  assign mem_addr   = mem_req ? row_addr : '0;
  assign mem_wdata  = mem_wen ? mrf_rdata : '0;
  assign mrf_rsel   = rs1_q;
  assign mrf_rrow   = row_q;
  assign mrf_wen    = (state_q == WAIT) && mem_rvalid;
  assign mrf_wsel   = rd_q;
  assign mrf_wrow   = row_q;
  assign mrf_wdata  = mrf_wen ? mem_rdata : '0;

`ifdef MATRIX_LS_PERF_CNT_EN
  logic [15:0] perf_loads_q, perf_stores_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_loads_q  <= 16'd0;
      perf_stores_q <= 16'd0;
    end else if (state_q == DONE) begin
      if (type_q == M_LOAD && perf_loads_q != 16'hFFFF)
        perf_loads_q <= perf_loads_q + 16'd1;
      if (type_q == M_STORE && perf_stores_q != 16'hFFFF)
        perf_stores_q <= perf_stores_q + 16'd1;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
`else
  assign perf_loads  = 16'd0;
  assign perf_stores = 16'd0;
`endif

endmodule

// File: tb/tb_matrix_ls_seq.sv
// Directed bench for matrix_ls_seq with a parameterisable-latency memory responder.
module tb_matrix_ls_seq;
  import types_pkg::*;

`ifdef MATRIX_LS_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  matrix_mem_t m_mem_type = M_NONE;
  logic [3:0]  matrix_rd = 4'd0, matrix_rs1 = 4'd0, stride = 4'd0;
  word_t       base_addr = '0;
  logic        mem_req, mem_ready, mem_wen, mem_rvalid;
  word_t       mem_addr;
  logic [63:0] mem_wdata, mem_rdata, mrf_wdata, mrf_rdata;
  logic        mrf_wen, busy, done;
  logic [3:0]  mrf_wsel, mrf_rsel;
  logic [1:0]  mrf_wrow, mrf_rrow;
  logic [15:0] perf_loads, perf_stores;

  always #5 CLK = ~CLK;

  matrix_ls_seq dut (
    .CLK(CLK), .RST(RST),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .m_mem_type(m_mem_type), .matrix_rd(matrix_rd), .matrix_rs1(matrix_rs1),
    .stride(stride), .base_addr(base_addr),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mrf_wen(mrf_wen), .mrf_wsel(mrf_wsel), .mrf_wrow(mrf_wrow), .mrf_wdata(mrf_wdata),
    .mrf_rsel(mrf_rsel), .mrf_rrow(mrf_rrow), .mrf_rdata(mrf_rdata),
    .busy(busy), .done(done),
    .perf_loads(perf_loads), .perf_stores(perf_stores)
  );

  // Memory responder: ready after ready_wait stall cycles, load data after rvalid_wait.
  int    ready_wait = 0, rvalid_wait = 0;
  int    req_cnt = 0, rv_cnt = 0;
  logic  pend = 1'b0, rv_force = 1'b0;
  word_t cap_addr = '0;

  assign mem_ready  = mem_req && (req_cnt >= ready_wait);
  assign mem_rvalid = (pend && (rv_cnt >= rvalid_wait)) || rv_force;
  assign mem_rdata  = {32'hDA7A_0000, cap_addr};
  assign mrf_rdata  = {28'hC0DE000, mrf_rsel, 30'h0, mrf_rrow};

  always @(posedge CLK) begin
    if (mem_rvalid) pend <= 1'b0;
    else if (pend)  rv_cnt <= rv_cnt + 1;
    if (mem_req && mem_ready) begin
      req_cnt <= 0;
      if (!mem_wen) begin
        pend     <= 1'b1;
        rv_cnt   <= 0;
        cap_addr <= mem_addr;
      end
    end else if (mem_req) begin
      req_cnt <= req_cnt + 1;
    end
  end

  // Monitor, sampling mid-cycle.
  int          cyc = 0;
  int          done_cnt = 0, done_cyc = 0, acc_cyc = 0, ld_hs = 0;
  int          stall_cyc = 0, stall_viol = 0;
  logic        prev_stall = 1'b0;
  word_t       prev_addr = '0;
  word_t       req_addr_q[$];
  logic        req_wen_q[$];
  logic [63:0] req_wdata_q[$];
  logic [3:0]  wr_sel_q[$];
  logic [1:0]  wr_row_q[$];
  logic [63:0] wr_data_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mem_req && mem_ready) begin
      req_addr_q.push_back(mem_addr);
      req_wen_q.push_back(mem_wen);
      req_wdata_q.push_back(mem_wdata);
      if (!mem_wen) ld_hs++;
    end
    if (mrf_wen) begin
      wr_sel_q.push_back(mrf_wsel);
      wr_row_q.push_back(mrf_wrow);
      wr_data_q.push_back(mrf_wdata);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (disp_valid && disp_ready && m_mem_type != M_NONE) acc_cyc = cyc;
    if (mem_req && prev_stall && mem_addr != prev_addr) stall_viol++;
    if (mem_req && !mem_ready) stall_cyc++;
    prev_stall = mem_req && !mem_ready;
    prev_addr  = mem_addr;
  end

  int    errors = 0, checks = 0;
  word_t exp_a[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=0x%0h expected=0x%0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete(); req_wen_q.delete(); req_wdata_q.delete();
    wr_sel_q.delete(); wr_row_q.delete(); wr_data_q.delete();
    stall_cyc = 0; stall_viol = 0;
  endtask

  task automatic issue(input matrix_mem_t t, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] st, input word_t base);
    clear_logs();
    m_mem_type = t; matrix_rd = rd; matrix_rs1 = rs1; stride = st; base_addr = base;
    disp_valid = 1'b1;
    tick(1);
    disp_valid = 1'b0;
    m_mem_type = M_NONE;
  endtask

  task automatic run_op(input string nm, input matrix_mem_t t, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] st, input word_t base);
    int d0;
    d0 = done_cnt;
    issue(t, rd, rs1, st, base);
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick(1);
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_rows(input string nm, input logic is_store, input logic [3:0] rg,
                            input int lat);
    chk({nm, "_nreq"}, 64'(req_addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(req_addr_q[i]), 64'(exp_a[i]));
      chk($sformatf("%s_wen%0d", nm, i), 64'(req_wen_q[i]), 64'(is_store));
      if (is_store)
        chk($sformatf("%s_wdata%0d", nm, i), req_wdata_q[i],
            {28'hC0DE000, rg, 30'h0, 2'(i)});
    end
    chk({nm, "_nwr"}, 64'(wr_sel_q.size()), is_store ? 64'd0 : 64'd4);
    for (int i = 0; i < 4 && i < wr_sel_q.size(); i++) begin
      chk($sformatf("%s_wsel%0d", nm, i), 64'(wr_sel_q[i]), 64'(rg));
      chk($sformatf("%s_wrow%0d", nm, i), 64'(wr_row_q[i]), 64'(i));
      chk($sformatf("%s_wdata%0d", nm, i), wr_data_q[i], {32'hDA7A_0000, exp_a[i]});
    end
    chk({nm, "_latency"}, 64'(done_cyc - acc_cyc + 1), 64'(lat));
  endtask

  initial begin
    int n_wr, n_done, h0;
    tick(3);
    RST = 1'b0;
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mrf_wen", 64'(mrf_wen), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mrf_sel_row", 64'({mrf_rsel, mrf_rrow, mrf_wsel, mrf_wrow}), 64'd0);
    chk("rst_perf", 64'({perf_loads, perf_stores}), 64'd0);

    // Zero-wait load, stride 0 -> 8-byte pitch, 10 cycles accept-to-done.
    run_op("ld0", M_LOAD, 4'd3, 4'd0, 4'd0, 32'h0000_1000);
    exp_a = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    check_rows("ld0", 1'b0, 4'd3, 10);

    // Zero-wait store of reg 5, stride 4 -> 32-byte pitch, 6 cycles.
    run_op("st0", M_STORE, 4'd0, 4'd5, 4'd4, 32'h0000_2000);
    exp_a = '{32'h2000, 32'h2020, 32'h2040, 32'h2060};
    check_rows("st0", 1'b1, 4'd5, 6);
    chk("perf_loads_a", 64'(perf_loads), PERF ? 64'd1 : 64'd0);
    chk("perf_stores_a", 64'(perf_stores), PERF ? 64'd1 : 64'd0);

    // Address wrap at the top of the 32-bit space.
    run_op("wrap", M_LOAD, 4'd9, 4'd0, 4'd1, 32'hFFFF_FFF0);
    exp_a = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    check_rows("wrap", 1'b0, 4'd9, 10);
    chk("perf_loads_b", 64'(perf_loads), PERF ? 64'd2 : 64'd0);
    chk("perf_stores_b", 64'(perf_stores), PERF ? 64'd1 : 64'd0);

    // Stalled load: 3 not-ready cycles per row, response 2 cycles late.
    // Each row = 4 REQ + 3 WAIT cycles -> 1 + 28 + 1 = 30 cycles.
    ready_wait = 3; rvalid_wait = 2;
    run_op("stall", M_LOAD, 4'd12, 4'd0, 4'd2, 32'h0000_4000);
    exp_a = '{32'h4000, 32'h4010, 32'h4020, 32'h4030};
    check_rows("stall", 1'b0, 4'd12, 30);
    chk("stall_cycles", 64'(stall_cyc), 64'd12);
    chk("stall_addr_unstable", 64'(stall_viol), 64'd0);

    // M_NONE dispatch and a stray response in IDLE must both be ignored.
    ready_wait = 0; rvalid_wait = 0;
    clear_logs();
    m_mem_type = M_NONE; disp_valid = 1'b1;
    tick(2);
    disp_valid = 1'b0;
    chk("none_busy", 64'(busy), 64'd0);
    chk("none_nreq", 64'(req_addr_q.size()), 64'd0);
    rv_force = 1'b1;
    tick(2);
    rv_force = 1'b0;
    chk("idle_rvalid_nwr", 64'(wr_sel_q.size()), 64'd0);

    // Reset while waiting for row 2's response; the late response must be dropped.
    rvalid_wait = 5;
    h0 = ld_hs;
    issue(M_LOAD, 4'd7, 4'd0, 4'd0, 32'h0000_8000);
    for (int i = 0; i < 100 && ld_hs != h0 + 3; i++) tick(1);
    chk("abort_reached_row2", 64'(ld_hs - h0), 64'd3);
    chk("abort_pre_nwr", 64'(wr_sel_q.size()), 64'd2);
    n_done = done_cnt;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_disp_ready", 64'(disp_ready), 64'd1);
    n_wr = wr_sel_q.size();
    tick(12);
    chk("abort_late_nwr", 64'(wr_sel_q.size()), 64'(n_wr));
    chk("abort_no_done", 64'(done_cnt), 64'(n_done));
    chk("abort_perf_cleared", 64'({perf_loads, perf_stores}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
